// File: rtl/dump_state_seq.sv
// Masked multi-channel state dump sequencer: freezes each selected correlator channel
// in turn and streams its state words to the buffer over a ready/valid write port.
module dump_state_seq #(
  parameter int NUM_CH    = 4,
  parameter int NUM_WORDS = 11,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  localparam int RD_CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int RD_WORD_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CH*NUM_WORDS*DATA_W-1:0] ch_state,
  input  logic                               dump_start,
  input  logic [NUM_CH-1:0]                  dump_mask,
  input  logic [ADDR_W-1:0]                  dump_base,
  output logic                               busy,
  output logic                               dump_done,
  output logic [NUM_CH-1:0]                  ch_freeze,
  output logic                               wr_en,
  output logic [ADDR_W-1:0]                  wr_addr,
  output logic [DATA_W-1:0]                  wr_data,
  input  logic                               wr_ready,
  input  logic [RD_CH_W-1:0]                 rd_ch,
  input  logic [RD_WORD_W-1:0]               rd_word,
  output logic [DATA_W-1:0]                  rd_data
);

  localparam int CH_PTR_W   = $clog2(NUM_CH + 1);
  localparam int WORD_PTR_W = RD_WORD_W;
  localparam int TOT        = NUM_CH * NUM_WORDS;
  localparam int TOT_W      = (TOT > 1) ? $clog2(TOT) : 1;

  localparam logic [CH_PTR_W-1:0]   CH_ONE    = CH_PTR_W'(1'b1);
  localparam logic [WORD_PTR_W-1:0] WORD_ONE  = WORD_PTR_W'(1'b1);
  localparam logic [WORD_PTR_W-1:0] LAST_WORD = WORD_PTR_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCAN   = 3'd1,
    S_FREEZE = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                  state_r, state_nx_s;
  logic [CH_PTR_W-1:0]     ch_ptr_r, ch_ptr_nx_s, found_idx_s;
  logic [WORD_PTR_W-1:0]   word_ptr_r, word_ptr_nx_s;
  logic [NUM_CH-1:0]       mask_r, mask_nx_s, freeze_nx_s;
  logic [ADDR_W-1:0]       base_r, base_nx_s, issue_addr_s;
  logic [TOT_W-1:0]        issue_idx_s, rd_idx_s;
  logic                    found_s, issue_s, rd_valid_s;
  logic                    busy_r, dump_done_r, wr_en_r;
  logic [NUM_CH-1:0]       ch_freeze_r;
  logic [ADDR_W-1:0]       wr_addr_r;
  logic [DATA_W-1:0]       wr_data_r, rd_data_r;
  logic [DATA_W-1:0]       words_s [TOT];

  for (genvar gi = 0; gi < TOT; gi++) begin : g_unpack
    assign words_s[gi] = ch_state[gi*DATA_W +: DATA_W];
  end

  // Lowest latched-mask channel at or above the current pointer
  always_comb begin
    found_s     = 1'b0;
    found_idx_s = {CH_PTR_W{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      found_idx_s = (mask_r[i] && (i >= int'(ch_ptr_r))) ? CH_PTR_W'(i) : found_idx_s;
      found_s     = found_s | (mask_r[i] && (i >= int'(ch_ptr_r)));
    end
  end

  // Next-state, pointer update and word-issue decision
  always_comb begin
    state_nx_s    = state_r;
    ch_ptr_nx_s   = ch_ptr_r;
    word_ptr_nx_s = word_ptr_r;
    mask_nx_s     = mask_r;
    base_nx_s     = base_r;
    issue_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (dump_start) begin
          mask_nx_s   = dump_mask;
          base_nx_s   = dump_base;
          ch_ptr_nx_s = {CH_PTR_W{1'b0}};
          state_nx_s  = S_SCAN;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_SCAN: begin
        if (found_s) begin
          ch_ptr_nx_s   = found_idx_s;
          word_ptr_nx_s = {WORD_PTR_W{1'b0}};
          state_nx_s    = S_FREEZE;
        end else begin
          state_nx_s = S_DONE;
        end
      end
      S_FREEZE: begin
        state_nx_s = S_WRITE;
        issue_s    = 1'b1;
      end
      S_WRITE: begin
        // wr_en is always high here, so wr_ready alone means the word was taken
        if (wr_ready) begin
          if (word_ptr_r == LAST_WORD) begin
            ch_ptr_nx_s   = ch_ptr_r + CH_ONE;
            word_ptr_nx_s = {WORD_PTR_W{1'b0}};
            state_nx_s    = S_SCAN;
          end else begin
            word_ptr_nx_s = word_ptr_r + WORD_ONE;
            issue_s       = 1'b1;
          end
        end else begin
          state_nx_s = S_WRITE;
        end
      end
      S_DONE:  state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Address, data index and freeze vector for the word about to go on the bus
  always_comb begin
    issue_addr_s = base_r + ADDR_W'(int'(ch_ptr_r) * NUM_WORDS) + ADDR_W'(word_ptr_nx_s);
    issue_idx_s  = TOT_W'(int'(ch_ptr_r) * NUM_WORDS + int'(word_ptr_nx_s));
    if ((state_nx_s == S_FREEZE) || (state_nx_s == S_WRITE)) begin
      freeze_nx_s = NUM_CH'(1'b1) << ch_ptr_nx_s;
    end else begin
      freeze_nx_s = {NUM_CH{1'b0}};
    end
  end

  // Sequencer state and registered dump-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      ch_ptr_r    <= {CH_PTR_W{1'b0}};
      word_ptr_r  <= {WORD_PTR_W{1'b0}};
      mask_r      <= {NUM_CH{1'b0}};
      base_r      <= {ADDR_W{1'b0}};
      busy_r      <= 1'b0;
      dump_done_r <= 1'b0;
      wr_en_r     <= 1'b0;
      ch_freeze_r <= {NUM_CH{1'b0}};
      wr_addr_r   <= {ADDR_W{1'b0}};
      wr_data_r   <= {DATA_W{1'b0}};
    end else begin
      state_r     <= state_nx_s;
      ch_ptr_r    <= ch_ptr_nx_s;
      word_ptr_r  <= word_ptr_nx_s;
      mask_r      <= mask_nx_s;
      base_r      <= base_nx_s;
      busy_r      <= (state_nx_s != S_IDLE);
      dump_done_r <= (state_nx_s == S_DONE);
      wr_en_r     <= (state_nx_s == S_WRITE);
      ch_freeze_r <= freeze_nx_s;
      if (issue_s) begin
        wr_addr_r <= issue_addr_s;
        wr_data_r <= words_s[issue_idx_s];
      end
    end
  end

  // Debug read port, out-of-range selections read as zero
  always_comb begin
    rd_valid_s = (int'(rd_ch) < NUM_CH) && (int'(rd_word) < NUM_WORDS);
    rd_idx_s   = TOT_W'(int'(rd_ch) * NUM_WORDS + int'(rd_word));
  end

  // Registered debug read data
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else if (rd_valid_s) begin
      rd_data_r <= words_s[rd_idx_s];
    end else begin
      rd_data_r <= {DATA_W{1'b0}};
    end
  end

  assign busy      = busy_r;
  assign dump_done = dump_done_r;
  assign ch_freeze = ch_freeze_r;
  assign wr_en     = wr_en_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;
  assign rd_data   = rd_data_r;

endmodule

// File: tb/tb_dump_state_seq.sv
// Directed bench for dump_state_seq: scenario tasks compare captured writes, pulse timing
// and the debug read port against values computed here.
module tb_dump_state_seq;
  localparam int NUM_CH = 4, NUM_WORDS = 11, DATA_W = 32, ADDR_W = 10;

  logic                               clk = 1'b0;
  logic                               rst;
  logic [NUM_CH*NUM_WORDS*DATA_W-1:0] ch_state;
  logic                               dump_start;
  logic [NUM_CH-1:0]                  dump_mask;
  logic [ADDR_W-1:0]                  dump_base;
  logic                               busy, dump_done, wr_en, wr_ready;
  logic [NUM_CH-1:0]                  ch_freeze;
  logic [ADDR_W-1:0]                  wr_addr;
  logic [DATA_W-1:0]                  wr_data, rd_data;
  logic [1:0]                         rd_ch;
  logic [3:0]                         rd_word;

  int checks = 0;
  int errors = 0;

  logic [9:0]  got_addr[$], exp_addr[$];
  logic [31:0] got_data[$], exp_data[$];
  logic [3:0]  got_frz[$],  exp_frz[$];
  int          done_cnt, done_cyc, first_wr_cyc, unstable_cnt;
  logic        busy_c1, busy_after;
  logic [3:0]  frz_c2;

  dump_state_seq #(.NUM_CH(NUM_CH), .NUM_WORDS(NUM_WORDS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .ch_state(ch_state), .dump_start(dump_start),
    .dump_mask(dump_mask), .dump_base(dump_base), .busy(busy), .dump_done(dump_done),
    .ch_freeze(ch_freeze), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_ch(rd_ch), .rd_word(rd_word), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_word(input int c, input int w);
    return {16'hA5C3, 8'(c), 8'(w)};
  endfunction

  task automatic build_exp(input logic [3:0] mask, input logic [9:0] base);
    exp_addr.delete(); exp_data.delete(); exp_frz.delete();
    for (int c = 0; c < NUM_CH; c++) begin
      if (mask[c]) begin
        for (int w = 0; w < NUM_WORDS; w++) begin
          exp_addr.push_back(base + 10'(c * NUM_WORDS + w));
          exp_data.push_back(exp_word(c, w));
          exp_frz.push_back(4'(1 << c));
        end
      end
    end
  endtask

  // Starts a dump and records every accepted write plus timing observations (no checking)
  task automatic run_dump(input logic [3:0] mask, input logic [9:0] base, input bit stall, input bit extra_start);
    logic        prev_stall = 1'b0;
    logic [9:0]  prev_addr = 10'h000;
    logic [31:0] prev_data = 32'h0;
    got_addr.delete(); got_data.delete(); got_frz.delete();
    done_cnt = 0; done_cyc = -1; first_wr_cyc = -1; unstable_cnt = 0;
    busy_c1 = 1'b0; busy_after = 1'b1; frz_c2 = 4'h0;
    @(negedge clk);
    dump_start = 1'b1; dump_mask = mask; dump_base = base; wr_ready = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      dump_start = 1'b0; dump_mask = ~mask; dump_base = ~base;
      if (extra_start && cyc == 4) begin
        dump_start = 1'b1; dump_mask = 4'hF; dump_base = 10'h000;
      end
      if (cyc == 1) busy_c1 = busy;
      if (cyc == 2) frz_c2 = ch_freeze;
      if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = busy;
      if (dump_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (prev_stall && (!wr_en || wr_addr !== prev_addr || wr_data !== prev_data)) unstable_cnt++;
      wr_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wr_en && wr_ready) begin
        got_addr.push_back(wr_addr); got_data.push_back(wr_data); got_frz.push_back(ch_freeze);
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
      end
      prev_stall = wr_en && !wr_ready; prev_addr = wr_addr; prev_data = wr_data;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    dump_start = 1'b0; wr_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, dump_done, ch_freeze, wr_en} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got busy=%b done=%b frz=%b wr_en=%b expected all 0", busy, dump_done, ch_freeze, wr_en);
    end
    checks++;
    if ({wr_addr, wr_data, rd_data} !== 74'b0) begin
      errors++; $display("FAIL reset_data got addr=%h data=%h rd=%h expected 0", wr_addr, wr_data, rd_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_channel();
    build_exp(4'b0001, 10'h100);
    run_dump(4'b0001, 10'h100, 1'b0, 1'b0);
    checks++;
    if (got_addr.size() !== 11) begin errors++; $display("FAIL t1_count got %0d expected 11", got_addr.size()); end
    for (int i = 0; i < exp_addr.size(); i++) begin
      checks++;
      if (i >= got_addr.size()) begin errors++; $display("FAIL t1_word%0d got none expected addr=%h", i, exp_addr[i]); end
      else if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_frz[i] !== exp_frz[i]) begin
        errors++; $display("FAIL t1_word%0d got %h/%h/%b expected %h/%h/%b", i, got_addr[i], got_data[i], got_frz[i], exp_addr[i], exp_data[i], exp_frz[i]);
      end
    end
    checks++;
    if (done_cyc !== 15 || done_cnt !== 1) begin errors++; $display("FAIL t1_done got cycle %0d count %0d expected cycle 15 count 1", done_cyc, done_cnt); end
    checks++;
    if (first_wr_cyc !== 3) begin errors++; $display("FAIL t1_first_write got cycle %0d expected 3", first_wr_cyc); end
    checks++;
    if (busy_c1 !== 1'b1 || busy_after !== 1'b0) begin errors++; $display("FAIL t1_busy got start=%b after_done=%b expected 1/0", busy_c1, busy_after); end
    checks++;
    if (frz_c2 !== 4'b0001) begin errors++; $display("FAIL t1_freeze_settle got %b expected 0001", frz_c2); end
  endtask

  task automatic test_two_channels();
    build_exp(4'b1010, 10'h000);
    run_dump(4'b1010, 10'h000, 1'b0, 1'b0);
    checks++;
    if (got_addr.size() !== 22) begin errors++; $display("FAIL t2_count got %0d expected 22", got_addr.size()); end
    for (int i = 0; i < exp_addr.size(); i++) begin
      checks++;
      if (i >= got_addr.size()) begin errors++; $display("FAIL t2_word%0d got none expected addr=%h", i, exp_addr[i]); end
      else if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_frz[i] !== exp_frz[i]) begin
        errors++; $display("FAIL t2_word%0d got %h/%h/%b expected %h/%h/%b", i, got_addr[i], got_data[i], got_frz[i], exp_addr[i], exp_data[i], exp_frz[i]);
      end
    end
    checks++;
    if (done_cyc !== 28 || done_cnt !== 1) begin errors++; $display("FAIL t2_done got cycle %0d count %0d expected cycle 28 count 1", done_cyc, done_cnt); end
    checks++;
    if (frz_c2 !== 4'b0010) begin errors++; $display("FAIL t2_freeze_settle got %b expected 0010", frz_c2); end
  endtask

  task automatic test_stall();
    build_exp(4'b0110, 10'h1F0);
    run_dump(4'b0110, 10'h1F0, 1'b1, 1'b0);
    checks++;
    if (got_addr.size() !== 22) begin errors++; $display("FAIL t3_count got %0d expected 22", got_addr.size()); end
    for (int i = 0; i < exp_addr.size(); i++) begin
      checks++;
      if (i >= got_addr.size()) begin errors++; $display("FAIL t3_word%0d got none expected addr=%h", i, exp_addr[i]); end
      else if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_frz[i] !== exp_frz[i]) begin
        errors++; $display("FAIL t3_word%0d got %h/%h/%b expected %h/%h/%b", i, got_addr[i], got_data[i], got_frz[i], exp_addr[i], exp_data[i], exp_frz[i]);
      end
    end
    checks++;
    if (unstable_cnt !== 0) begin errors++; $display("FAIL t3_stall_stable got %0d changes expected 0", unstable_cnt); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL t3_done_count got %0d expected 1", done_cnt); end
  endtask

  task automatic test_wrap();
    build_exp(4'b0001, 10'h3FC);
    run_dump(4'b0001, 10'h3FC, 1'b0, 1'b0);
    checks++;
    if (got_addr.size() !== 11) begin errors++; $display("FAIL t4_count got %0d expected 11", got_addr.size()); end
    for (int i = 0; i < exp_addr.size(); i++) begin
      checks++;
      if (i >= got_addr.size()) begin errors++; $display("FAIL t4_word%0d got none expected addr=%h", i, exp_addr[i]); end
      else if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        errors++; $display("FAIL t4_word%0d got %h/%h expected %h/%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_empty_and_busy();
    run_dump(4'b0000, 10'h055, 1'b0, 1'b0);
    checks++;
    if (got_addr.size() !== 0) begin errors++; $display("FAIL t5_empty_writes got %0d expected 0", got_addr.size()); end
    checks++;
    if (done_cyc !== 2 || done_cnt !== 1) begin errors++; $display("FAIL t5_empty_done got cycle %0d count %0d expected cycle 2 count 1", done_cyc, done_cnt); end
    build_exp(4'b0010, 10'h010);
    run_dump(4'b0010, 10'h010, 1'b0, 1'b1);
    checks++;
    if (got_addr.size() !== 11) begin errors++; $display("FAIL t5_busy_count got %0d expected 11", got_addr.size()); end
    for (int i = 0; i < exp_addr.size(); i++) begin
      checks++;
      if (i >= got_addr.size()) begin errors++; $display("FAIL t5_word%0d got none expected addr=%h", i, exp_addr[i]); end
      else if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        errors++; $display("FAIL t5_word%0d got %h/%h expected %h/%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
    checks++;
    if (done_cyc !== 15 || done_cnt !== 1) begin errors++; $display("FAIL t5_busy_done got cycle %0d count %0d expected cycle 15 count 1", done_cyc, done_cnt); end
  endtask

  task automatic test_reset_mid_dump();
    int bad = 0;
    @(negedge clk);
    dump_start = 1'b1; dump_mask = 4'b0100; dump_base = 10'h000; wr_ready = 1'b1;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      dump_start = 1'b0;
    end
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 10'd26 || wr_data !== exp_word(2, 4) || ch_freeze !== 4'b0100) begin
      errors++; $display("FAIL t6_fifth_word got en=%b addr=%h data=%h frz=%b expected 1/01a/%h/0100", wr_en, wr_addr, wr_data, ch_freeze, exp_word(2, 4));
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, dump_done, ch_freeze, wr_en, wr_addr, wr_data, rd_data} !== 81'b0) begin
      errors++; $display("FAIL t6_after_rst got busy=%b done=%b frz=%b en=%b addr=%h data=%h rd=%h expected all 0", busy, dump_done, ch_freeze, wr_en, wr_addr, wr_data, rd_data);
    end
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (dump_done || wr_en || busy) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL t6_quiet_after_rst got %0d active cycles expected 0", bad); end
    build_exp(4'b0100, 10'h050);
    run_dump(4'b0100, 10'h050, 1'b0, 1'b0);
    checks++;
    if (got_addr.size() !== 11) begin errors++; $display("FAIL t6_rerun_count got %0d expected 11", got_addr.size()); end
    for (int i = 0; i < exp_addr.size(); i++) begin
      checks++;
      if (i >= got_addr.size()) begin errors++; $display("FAIL t6_word%0d got none expected addr=%h", i, exp_addr[i]); end
      else if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_frz[i] !== exp_frz[i]) begin
        errors++; $display("FAIL t6_word%0d got %h/%h/%b expected %h/%h/%b", i, got_addr[i], got_data[i], got_frz[i], exp_addr[i], exp_data[i], exp_frz[i]);
      end
    end
    checks++;
    if (done_cyc !== 15 || done_cnt !== 1) begin errors++; $display("FAIL t6_rerun_done got cycle %0d count %0d expected cycle 15 count 1", done_cyc, done_cnt); end
  endtask

  task automatic test_read_port();
    logic [1:0]  ch_v [5]  = '{2'd2, 2'd0, 2'd3, 2'd1, 2'd2};
    logic [3:0]  wd_v [5]  = '{4'd3, 4'd0, 4'd10, 4'd11, 4'd15};
    logic [31:0] exp_v [5];
    exp_v[0] = exp_word(2, 3); exp_v[1] = exp_word(0, 0); exp_v[2] = exp_word(3, 10);
    exp_v[3] = 32'h0; exp_v[4] = 32'h0;
    for (int i = 0; i < 5; i++) begin
      rd_ch = ch_v[i]; rd_word = wd_v[i];
      @(negedge clk);
      checks++;
      if (rd_data !== exp_v[i]) begin
        errors++; $display("FAIL rd_ch%0d_word%0d got %h expected %h", ch_v[i], wd_v[i], rd_data, exp_v[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; dump_start = 1'b0; dump_mask = 4'h0; dump_base = 10'h000;
    wr_ready = 1'b1; rd_ch = 2'd0; rd_word = 4'd0;
    for (int c = 0; c < NUM_CH; c++)
      for (int w = 0; w < NUM_WORDS; w++)
        ch_state[(c*NUM_WORDS+w)*DATA_W +: DATA_W] = exp_word(c, w);
    test_reset();
    test_single_channel();
    test_two_channels();
    test_stall();
    test_wrap();
    test_empty_and_busy();
    test_reset_mid_dump();
    test_read_port();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
